// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding, slave command codes,
// default bus widths and a small index-width helper.
package crossbar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Bits needed to index n entries (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slave_port_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin picker. Returns the first
// requester (req with mask bits removed) at or after ptr, wrapping at N-1 -> 0.
module rr_pick
    import crossbar_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic          valid,
    output logic [IW-1:0] index
);

    localparam int SW = IW + 1;

    logic [N-1:0]  eligible;
    logic [SW-1:0] cand;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign eligible[gi] = req[gi] & ~mask[gi];
        end
    endgenerate

    // Scan offsets from far to near so the nearest eligible requester wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + SW'(k);
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (eligible[cand[IW-1:0]]) begin
                valid = 1'b1;
                index = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter: slave-side crossbar port. Grants one master at a time
// round-robin, drives the slave from the registered owner and returns the
// slave's ack/rdata to that owner only.
// Optional watchdog: define SLAVE_ARB_TIMEOUT_EN to error-terminate transfers
// that see no s_ack for TIMEOUT_CYCLES busy cycles.
module slave_port_arbiter
    import crossbar_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_cmd,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              s_cs,
    output logic                              s_cmd,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_ack
);

    localparam int IW = idx_width(NUM_MASTERS);

    arb_state_t                state_reg, state_next;
    logic [IW-1:0]             owner_reg, owner_next;
    logic [IW-1:0]             rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]             owner_inc;

    logic                      pick_valid;
    logic [IW-1:0]             pick_index;
    logic [IW-1:0]             pick_ptr;
    logic [NUM_MASTERS-1:0]    pick_mask;
    logic [NUM_MASTERS-1:0]    owner_onehot;

    logic                      busy;
    logic                      timeout;
    logic                      complete;

    logic [ADDR_WIDTH-1:0]     addr_arr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]     wdata_arr [NUM_MASTERS];

    assign busy      = (state_reg == BUSY);
    assign owner_inc = (owner_reg == IW'(NUM_MASTERS - 1)) ? '0 : owner_reg + 1'b1;

    // A transfer ends on slave ack or watchdog expiry; a reset cycle abandons it.
    assign complete  = busy & ~rst & (s_ack | timeout);

    // Per-master views: owner decode and request slices as arrays for muxing.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign owner_onehot[gi] = (owner_reg == IW'(gi));
            assign addr_arr[gi]     = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]    = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // While busy, re-arbitration starts just past the owner and skips it, so a
    // master can never win two transfers in a row without an idle cycle.
    assign pick_ptr  = busy ? owner_inc : rr_ptr_reg;
    assign pick_mask = busy ? owner_onehot : '0;

    rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req   (m_req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .valid (pick_valid),
        .index (pick_index)
    );

`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WDOG_W-1:0] wdog_reg, wdog_next;

    // Watchdog register: counts busy cycles that have not completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_reg <= '0;
        end else begin
            wdog_reg <= wdog_next;
        end
    end

    // Any completion (or leaving BUSY) restarts the count for the next owner.
    always_comb begin
        wdog_next = '0;
        if (busy && !complete) begin
            wdog_next = wdog_reg + 1'b1;
        end
    end

    assign timeout = busy & ~s_ack & (wdog_reg == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // State register: FSM state, current owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Next-state logic: grant from IDLE, hand over or release on completion.
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BUSY;
                    owner_next = pick_index;
                end
            end
            BUSY: begin
                if (complete) begin
                    rr_ptr_next = owner_inc;
                    if (pick_valid) begin
                        owner_next = pick_index;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slave-side outputs come only from registered state and the owner's slices.
    always_comb begin
        s_cs    = 1'b0;
        s_cmd   = CMD_READ;
        s_addr  = '0;
        s_wdata = '0;
        if (busy) begin
            s_cs    = 1'b1;
            s_cmd   = m_cmd[owner_reg];
            s_addr  = addr_arr[owner_reg];
            s_wdata = wdata_arr[owner_reg];
        end
    end

    // Master-side responses: only the owner's lane ever carries ack/err/rdata.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
            assign m_ack[gi] = complete & owner_onehot[gi];
            assign m_err[gi] = complete & timeout & owner_onehot[gi];
            assign m_rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
                (complete && owner_onehot[gi] && !timeout && (s_cmd == CMD_READ))
                    ? s_rdata : '0;
        end
    endgenerate

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench for slave_port_arbiter: directed scenarios with literal expectations,
// then randomized masters and slave stalls checked every cycle against a
// transfer-level reference model. Honours SLAVE_ARB_TIMEOUT_EN.
module tb_slave_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;
`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req, m_cmd, m_ack, m_err;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata, m_rdata;
    logic            s_cs, s_cmd, s_ack, ack_en;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [DW-1:0]   mem [16];

    int vectors     = 0;
    int miscompares = 0;

    slave_port_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_cmd   (m_cmd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_cs    (s_cs),
        .s_cmd   (s_cmd),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    always #5 clk = ~clk;

    // RAM slave: combinational ack gated by ack_en, 16-word memory.
    assign s_ack   = s_cs & ack_en;
    assign s_rdata = mem[s_addr[3:0]];
    always @(posedge clk) begin
        if (s_cs && s_ack && s_cmd) mem[s_addr[3:0]] <= s_wdata;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transfer level) ----------------
    bit           mdl_busy  = 1'b0;
    int           mdl_owner = 0;
    int           mdl_ptr   = 0;
    int           mdl_wdog  = 0;
    logic [N-1:0] last_ack  = '0;

    function automatic int search(input int from, input logic [N-1:0] req, input int skip);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (from + k) % N;
            if (req[c] && c != skip) return c;
        end
        return -1;
    endfunction

    logic            e_cs, e_cmd, e_to, e_done;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic [N-1:0]    e_ack, e_err;
    logic [N*DW-1:0] e_rdata;
    int              nxt;

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        e_cs = mdl_busy; e_cmd = 1'b0; e_addr = '0; e_wdata = '0;
        e_to = 1'b0; e_done = 1'b0; e_ack = '0; e_err = '0; e_rdata = '0;
        if (mdl_busy) begin
            e_cmd   = m_cmd[mdl_owner];
            e_addr  = m_addr[mdl_owner*AW +: AW];
            e_wdata = m_wdata[mdl_owner*DW +: DW];
            e_to    = TO_EN && !s_ack && (mdl_wdog == T - 1);
            e_done  = !rst && (s_ack || e_to);
        end
        if (e_done) begin
            e_ack[mdl_owner] = 1'b1;
            if (e_to) e_err[mdl_owner] = 1'b1;
            else if (e_cmd == 1'b0) e_rdata[mdl_owner*DW +: DW] = s_rdata;
            $display("xfer t=%0t master=%0d %s addr=%h wdata=%h rdata=%h timeout=%0d",
                     $time, mdl_owner, e_cmd ? "WR" : "RD", e_addr, e_wdata,
                     e_rdata[mdl_owner*DW +: DW], e_to);
        end
        chk("s_cs",    s_cs,    e_cs);
        chk("s_cmd",   s_cmd,   e_cmd);
        chk("s_addr",  s_addr,  e_addr);
        chk("s_wdata", s_wdata, e_wdata);
        chk("m_ack",   m_ack,   e_ack);
        chk("m_err",   m_err,   e_err);
        chk("m_rdata", m_rdata, e_rdata);
        last_ack = e_ack;

        if (rst) begin
            mdl_busy = 1'b0; mdl_owner = 0; mdl_ptr = 0; mdl_wdog = 0;
        end else if (mdl_busy) begin
            if (e_done) begin
                mdl_ptr  = (mdl_owner + 1) % N;
                mdl_wdog = 0;
                nxt = search(mdl_ptr, m_req, mdl_owner);
                if (nxt >= 0) mdl_owner = nxt;
                else mdl_busy = 1'b0;
            end else begin
                mdl_wdog++;
            end
        end else begin
            nxt = search(mdl_ptr, m_req, -1);
            if (nxt >= 0) begin
                mdl_busy = 1'b1; mdl_owner = nxt; mdl_wdog = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(); rst = 1'b1; m_req = '0; look();
        step(); rst = 1'b0; look();
    endtask

    logic [N-1:0] ack_seq [4];

    initial begin
        rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0; ack_en = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        ack_seq[0] = 4'b0001; ack_seq[1] = 4'b0010; ack_seq[2] = 4'b0001; ack_seq[3] = 4'b0010;

        // Reset state
        step(); step(); look();
        chk("reset_s_cs", s_cs, 0);
        chk("reset_m_ack", m_ack, 0);

        // Single write then read through master 0
        step(); rst = 1'b0; ack_en = 1'b1; m_req = 4'b0001; m_cmd[0] = 1'b1;
        m_addr[0 +: AW] = 32'd5; m_wdata[0 +: DW] = 32'hDEADBEEF; look();
        chk("wr_cycle0_s_cs", s_cs, 0);
        step(); look();
        chk("wr_s_cs", s_cs, 1);
        chk("wr_s_cmd", s_cmd, 1);
        chk("wr_s_addr", s_addr, 5);
        chk("wr_m_ack", m_ack, 4'b0001);
        step(); m_cmd[0] = 1'b0; look();
        chk("rd_idle_gap", s_cs, 0);
        step(); look();
        chk("rd_m_ack", m_ack, 4'b0001);
        chk("rd_slice0", m_rdata[0 +: DW], 32'hDEADBEEF);
        chk("rd_slice1", m_rdata[DW +: DW], 0);
        step(); m_req = '0; look();

        // Contention: two masters alternate with no idle gap
        do_reset();
        step(); m_req = 4'b0011; m_cmd = 4'b0011; look();
        for (int k = 0; k < 4; k++) begin
            step(); look();
            chk($sformatf("contend_ack%0d", k), m_ack, ack_seq[k]);
            chk($sformatf("contend_cs%0d", k), s_cs, 1);
        end
        step(); m_req = '0; look();
        step(); look();

        // Fairness wrap: make rr_ptr=3, then 1001 grants 3 then 0
        do_reset();
        step(); m_req = 4'b0100; look();
        step(); look();
        chk("wrap_prep_ack", m_ack, 4'b0100);
        step(); m_req = 4'b1001; look();
        chk("wrap_idle", s_cs, 0);
        step(); look();
        chk("wrap_first_m3", m_ack, 4'b1000);
        step(); m_req = 4'b0001; look();
        chk("wrap_then_m0", m_ack, 4'b0001);
        step(); m_req = '0; look();

        // Reset in the middle of a stalled transfer
        step(); ack_en = 1'b0; m_req = 4'b0001; look();
        step(); look();
        chk("rstmid_busy", s_cs, 1);
        step(); rst = 1'b1; look();
        chk("rstmid_during_ack", m_ack, 0);
        step(); rst = 1'b0; m_req = '0; look();
        chk("rstmid_after_cs", s_cs, 0);
        chk("rstmid_after_ack", m_ack, 0);
        step(); m_req = 4'b0011; ack_en = 1'b1; look();
        step(); look();
        chk("rstmid_ptr_zero", m_ack, 4'b0001);
        step(); m_req = '0; look();
        step(); look();

        // Watchdog behaviour
        step(); ack_en = 1'b0; m_req = 4'b0001; m_cmd = '0; look();
        if (TO_EN) begin
            for (int k = 1; k <= T; k++) begin
                step(); look();
                chk($sformatf("to_ack_c%0d", k), m_ack, (k == T) ? 4'b0001 : 4'b0000);
                chk($sformatf("to_err_c%0d", k), m_err, (k == T) ? 4'b0001 : 4'b0000);
            end
            chk("to_rdata", m_rdata, 0);
            step(); m_req = '0; look();
        end else begin
            for (int k = 0; k < 100; k++) begin
                step(); look();
                chk("stall_cs", s_cs, 1);
                chk("stall_err", m_err, 0);
            end
            do_reset();
        end

        // Same master re-requesting: BUSY, IDLE, BUSY, IDLE
        step(); ack_en = 1'b1; m_req = 4'b0001; look();
        for (int k = 0; k < 4; k++) begin
            step(); look();
            chk($sformatf("same_cs%0d", k), s_cs, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        step(); m_req = '0; look();
        step(); look();

        // Randomized masters, slave stalls and occasional resets
        for (int c = 0; c < 3000; c++) begin
            step();
            rst    = ($urandom_range(0, 199) == 0);
            ack_en = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N; i++) begin
                if (!m_req[i] || last_ack[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        m_req[i]             = 1'b1;
                        m_cmd[i]             = 1'($urandom_range(0, 1));
                        m_addr[i*AW +: AW]   = $urandom;
                        m_wdata[i*DW +: DW]  = $urandom;
                    end else begin
                        m_req[i] = 1'b0;
                    end
                end
            end
            look();
        end

        step(); rst = 1'b0; m_req = '0; ack_en = 1'b1; look();
        repeat (3) begin step(); look(); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
